// File: rtl/record_fifo_pkg.sv
// Shared helpers for the record stream FIFO: derived pointer width and
// modulo pointer distance.
package record_fifo_pkg;

   typedef logic [31:0] ptr32_t;

   function automatic int unsigned calc_ptr_w(input int unsigned storage_size);
      return $clog2(storage_size) + 32'd1;
   endfunction

   // Distance a-b on pointers that wrap modulo 2**ptr_w.
   function automatic ptr32_t ptr_diff(input ptr32_t a, input ptr32_t b, input int unsigned ptr_w);
      ptr32_t mask;
      mask = (32'd1 << ptr_w) - 32'd1;
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/record_fifo_mem.sv
// Word-write / record-read storage array for the record stream FIFO.
// The read port is combinational and returns one aligned record.
module record_fifo_mem
   import record_fifo_pkg::*;
#(
   parameter  int unsigned WORD_SIZE    = 8,
   parameter  int unsigned RECORD_WORDS = 16,
   parameter  int unsigned SLOTS        = 8,
   localparam int unsigned STORAGE_SIZE = SLOTS * RECORD_WORDS,
   localparam int unsigned IDX_W        = $clog2(STORAGE_SIZE),
   localparam int unsigned SLOT_W       = $clog2(SLOTS),
   localparam int unsigned OFF_W        = $clog2(RECORD_WORDS),
   localparam int unsigned REC_W        = WORD_SIZE * RECORD_WORDS
) (
   input  logic                 clk,
   input  logic                 i_wr_en,
   input  logic [IDX_W-1:0]     i_wr_idx,
   input  logic [WORD_SIZE-1:0] i_wr_data,
   input  logic [SLOT_W-1:0]    i_rd_rec,
   output logic [REC_W-1:0]     o_rd_data
);

   logic [WORD_SIZE-1:0] r_mem [STORAGE_SIZE];

   // Storage write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   for (genvar g = 0; g < RECORD_WORDS; g++) begin : g_rd
      localparam logic [OFF_W-1:0] OFF = OFF_W'(g);
      assign o_rd_data[g*WORD_SIZE +: WORD_SIZE] = r_mem[{i_rd_rec, OFF}];
   end

endmodule

// File: rtl/record_stream_fifo.sv
// Word-in / record-out FIFO with commit-on-record-boundary, partial flush,
// a valid/ready registered output stage and occupancy status.
module record_stream_fifo
   import record_fifo_pkg::*;
#(
   parameter  int unsigned WORD_SIZE         = 8,
   parameter  int unsigned RECORD_WORDS      = 16,
   parameter  int unsigned SLOTS             = 8,
   parameter  int unsigned ALMOST_FULL_WORDS = 16,
   localparam int unsigned STORAGE_SIZE      = SLOTS * RECORD_WORDS,
   localparam int unsigned PTR_W             = calc_ptr_w(STORAGE_SIZE),
   localparam int unsigned REC_W             = WORD_SIZE * RECORD_WORDS,
   localparam int unsigned REC_CNT_W         = $clog2(SLOTS) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 write_en,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 flush,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [REC_W-1:0]     data_out,
   output logic [REC_CNT_W-1:0] records,
   output logic [PTR_W-1:0]     free_words,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow
);

   localparam int unsigned    REC_SH  = $clog2(RECORD_WORDS);
   localparam logic [PTR_W-1:0] STORE_SZ = PTR_W'(STORAGE_SIZE);
   localparam logic [PTR_W-1:0] AF_THR   = PTR_W'(ALMOST_FULL_WORDS);
   localparam logic [PTR_W-1:0] REC_INC  = PTR_W'(RECORD_WORDS);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_commit_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             r_out_valid;
   logic [REC_W-1:0] r_data_out;
   logic             r_overflow;

   logic [PTR_W-1:0] w_used;
   logic [PTR_W-1:0] w_free;
   logic [PTR_W-1:0] w_wr_ptr_inc;
   logic             w_full;
   logic             w_wr_accept;
   logic             w_load;
   logic [REC_W-1:0] w_rd_data;

   assign w_used       = PTR_W'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), PTR_W));
   assign w_free       = STORE_SZ - w_used;
   assign w_full       = (w_free == {PTR_W{1'b0}});
   assign w_wr_accept  = write_en && !w_full && !flush;
   assign w_wr_ptr_inc = r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
   // Load compares against the pre-edge commit pointer, so a record
   // committed this edge is picked up one cycle later.
   assign w_load       = (!r_out_valid || out_ready) && (r_commit_ptr != r_rd_ptr);

   record_fifo_mem #(
      .WORD_SIZE   (WORD_SIZE),
      .RECORD_WORDS(RECORD_WORDS),
      .SLOTS       (SLOTS)
   ) u_mem (
      .clk      (clk),
      .i_wr_en  (w_wr_accept),
      .i_wr_idx (r_wr_ptr[PTR_W-2:0]),
      .i_wr_data(data_in),
      .i_rd_rec (r_rd_ptr[PTR_W-2:REC_SH]),
      .o_rd_data(w_rd_data)
   );

   // Write and commit pointers; flush rewinds to the last record boundary.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr     <= {PTR_W{1'b0}};
         r_commit_ptr <= {PTR_W{1'b0}};
         r_overflow   <= 1'b0;
      end else begin
         if (flush) begin
            r_wr_ptr <= r_commit_ptr;
         end else if (w_wr_accept) begin
            r_wr_ptr <= w_wr_ptr_inc;
            if (w_wr_ptr_inc[REC_SH-1:0] == {REC_SH{1'b0}}) begin
               r_commit_ptr <= w_wr_ptr_inc;
            end
         end else if (write_en) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Output register stage and read pointer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_ptr    <= {PTR_W{1'b0}};
         r_out_valid <= 1'b0;
         r_data_out  <= {REC_W{1'b0}};
      end else if (w_load) begin
         r_data_out  <= w_rd_data;
         r_out_valid <= 1'b1;
         r_rd_ptr    <= r_rd_ptr + REC_INC;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign data_out    = r_data_out;
   assign overflow    = r_overflow;
   assign free_words  = w_free;
   assign full        = w_full;
   assign almost_full = (w_free < AF_THR);
   assign records     = REC_CNT_W'(ptr_diff(32'(r_commit_ptr), 32'(r_rd_ptr), PTR_W) >> REC_SH);

endmodule

// File: tb/tb_record_stream_fifo.sv
// Randomised, self-checking bench for record_stream_fifo against a
// queue-based model of committed words, the partial record and the output stage.
module tb_record_stream_fifo;

   localparam int WS = 8;
   localparam int RW = 4;
   localparam int SL = 4;
   localparam int AF = 4;
   localparam int SS = SL * RW;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        write_en = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [31:0] data_out;
   logic [2:0]  records;
   logic [4:0]  free_words;
   logic        full;
   logic        almost_full;
   logic        overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [7:0]  m_comm[$];
   logic [7:0]  m_part[$];
   bit          m_ov  = 1'b0;
   bit          m_ovf = 1'b0;
   logic [31:0] m_out = 32'h0;

   record_stream_fifo #(
      .WORD_SIZE(WS), .RECORD_WORDS(RW), .SLOTS(SL), .ALMOST_FULL_WORDS(AF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .write_en(write_en), .data_in(data_in),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
      .data_out(data_out), .records(records), .free_words(free_words),
      .full(full), .almost_full(almost_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic int m_free();
      return SS - m_comm.size() - m_part.size();
   endfunction

   function automatic int m_recs();
      return m_comm.size() / RW;
   endfunction

   function automatic logic [31:0] seq_rec(input int r);
      logic [31:0] rec = 32'h0;
      for (int k = RW - 1; k >= 0; k--) rec = (rec << 8) | 32'((r * RW + k) & 255);
      return rec;
   endfunction

   task automatic model_edge(input bit rst, input bit we, input logic [7:0] d, input bit fl, input bit rdy);
      int  free;
      bit  load;
      logic [31:0] rec;
      if (rst) begin
         m_comm.delete(); m_part.delete();
         m_ov = 1'b0; m_ovf = 1'b0; m_out = 32'h0;
         return;
      end
      free = m_free();
      load = (!m_ov || rdy) && (m_comm.size() >= RW);
      if (load) begin
         rec = 32'h0;
         for (int k = RW - 1; k >= 0; k--) rec = (rec << 8) | 32'(m_comm[k]);
         repeat (RW) void'(m_comm.pop_front());
         m_out = rec;
         m_ov  = 1'b1;
      end else if (m_ov && rdy) begin
         m_ov = 1'b0;
      end
      if (fl) begin
         m_part.delete();
      end else if (we && free > 0) begin
         m_part.push_back(d);
         if (m_part.size() == RW) begin
            foreach (m_part[k]) m_comm.push_back(m_part[k]);
            m_part.delete();
         end
      end else if (we) begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic step(input bit we, input logic [7:0] d, input bit fl, input bit rdy);
      write_en = we; data_in = d; flush = fl; out_ready = rdy;
      @(posedge clk);
      model_edge(!reset_n, we, d, fl, rdy);
      #1;
      write_en = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(1'b1, 8'h55, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      reset_n = 1'b1;
      n_cmp += 7;
      if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      if (data_out !== 32'h0)    begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_out); end
      if (records !== 3'd0)      begin n_fail++; $display("FAIL reset_records got=%0d exp=0", records); end
      if (free_words !== 5'd16)  begin n_fail++; $display("FAIL reset_free got=%0d exp=16", free_words); end
      if (full !== 1'b0)         begin n_fail++; $display("FAIL reset_full got=%0b exp=0", full); end
      if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
      if (overflow !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
   endtask

   task automatic test_single_record();
      do_reset();
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
      n_cmp += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%0b exp=0", out_valid); end
      if (records !== 3'd1)   begin n_fail++; $display("FAIL single_committed got=%0d exp=1", records); end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp += 2;
      if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
      if (data_out !== 32'h04030201) begin n_fail++; $display("FAIL single_data got=%h exp=04030201", data_out); end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got=%0b exp=0", out_valid); end
   endtask

   task automatic test_fill_backpressure();
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      n_cmp += 2;
      if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full got=%0b exp=1", full); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got=%0b exp=0", overflow); end
      step(1'b1, 8'h14, 1'b0, 1'b0);
      n_cmp += 4;
      if (overflow !== 1'b1)    begin n_fail++; $display("FAIL fill_ovf got=%0b exp=1", overflow); end
      if (records !== 3'd4)     begin n_fail++; $display("FAIL fill_records got=%0d exp=4", records); end
      if (free_words !== 5'd0)  begin n_fail++; $display("FAIL fill_free got=%0d exp=0", free_words); end
      if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af got=%0b exp=1", almost_full); end
      for (int r = 0; r < 5; r++) begin
         n_cmp += 2;
         if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL drain_valid rec=%0d got=%0b exp=1", r, out_valid); end
         if (data_out !== seq_rec(r)) begin n_fail++; $display("FAIL drain_data rec=%0d got=%h exp=%h", r, data_out, seq_rec(r)); end
         step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      step(1'b1, 8'hAA, 1'b0, 1'b1);
      step(1'b1, 8'hBB, 1'b0, 1'b1);
      step(1'b1, 8'hCC, 1'b1, 1'b1);
      n_cmp += 3;
      if (free_words !== 5'd16) begin n_fail++; $display("FAIL flush_free got=%0d exp=16", free_words); end
      if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
      if (overflow !== 1'b0)    begin n_fail++; $display("FAIL flush_ovf got=%0b exp=0", overflow); end
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp += 2;
      if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL flush_after_valid got=%0b exp=1", out_valid); end
      if (data_out !== 32'h13121110) begin n_fail++; $display("FAIL flush_after_data got=%h exp=13121110", data_out); end
   endtask

   task automatic test_wrap();
      int wr_word = 0;
      int rd_rec  = 0;
      int cyc     = 0;
      bit rdy, we;
      do_reset();
      while (rd_rec < 40 && cyc < 3000) begin
         rdy = cyc[0];
         we  = (wr_word < 40 * RW) && (m_free() > 0) && ($urandom_range(0, 7) != 0);
         if (out_valid && rdy) begin
            n_cmp++;
            if (data_out !== seq_rec(rd_rec)) begin
               n_fail++; $display("FAIL wrap_data rec=%0d got=%h exp=%h", rd_rec, data_out, seq_rec(rd_rec));
            end
            rd_rec++;
         end
         step(we, 8'(wr_word & 255), 1'b0, rdy);
         if (we) wr_word++;
         n_cmp++;
         if (out_valid !== m_ov) begin n_fail++; $display("FAIL wrap_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_ov); end
         cyc++;
      end
      n_cmp += 2;
      if (rd_rec != 40)      begin n_fail++; $display("FAIL wrap_count got=%0d exp=40", rd_rec); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%0b exp=0", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      n_cmp++;
      if (records !== 3'd2) begin n_fail++; $display("FAIL mid_pre_records got=%0d exp=2", records); end
      do_reset();
      n_cmp += 4;
      if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
      if (records !== 3'd0)     begin n_fail++; $display("FAIL mid_records got=%0d exp=0", records); end
      if (free_words !== 5'd16) begin n_fail++; $display("FAIL mid_free got=%0d exp=16", free_words); end
      if (overflow !== 1'b0)    begin n_fail++; $display("FAIL mid_ovf got=%0b exp=0", overflow); end
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp += 2;
      if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL mid_after_valid got=%0b exp=1", out_valid); end
      if (data_out !== 32'h24232221) begin n_fail++; $display("FAIL mid_after_data got=%h exp=24232221", data_out); end
   endtask

   task automatic test_hold();
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
         n_cmp += 2;
         if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL hold_valid cyc=%0d got=%0b exp=1", i, out_valid); end
         if (data_out !== 32'h43424140) begin n_fail++; $display("FAIL hold_data cyc=%0d got=%h exp=43424140", i, data_out); end
      end
      n_cmp++;
      if (records !== 3'd2) begin n_fail++; $display("FAIL hold_records got=%0d exp=2", records); end
   endtask

   task automatic test_random();
      bit we, fl, rdy;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         we  = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 2) == 0);
         step(we, 8'($urandom), fl, rdy);
         n_cmp += 7;
         if (out_valid !== m_ov)            begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, out_valid, m_ov); end
         if (data_out !== m_out)            begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, data_out, m_out); end
         if (int'(records) != m_recs())     begin n_fail++; $display("FAIL rand_records cyc=%0d got=%0d exp=%0d", c, records, m_recs()); end
         if (int'(free_words) != m_free())  begin n_fail++; $display("FAIL rand_free cyc=%0d got=%0d exp=%0d", c, free_words, m_free()); end
         if (full !== (m_free() == 0))      begin n_fail++; $display("FAIL rand_full cyc=%0d got=%0b exp=%0b", c, full, (m_free() == 0)); end
         if (almost_full !== (m_free() < AF)) begin n_fail++; $display("FAIL rand_af cyc=%0d got=%0b exp=%0b", c, almost_full, (m_free() < AF)); end
         if (overflow !== m_ovf)            begin n_fail++; $display("FAIL rand_ovf cyc=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
      end
   endtask

   initial begin
      test_reset();
      test_single_record();
      test_fill_backpressure();
      test_flush();
      test_wrap();
      test_reset_mid();
      test_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_fail);
      $fatal(1, "timeout");
   end

endmodule
